// File: rtl/csi2_raw10_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : csi2_raw10_line_unpacker
// Brief    : Unpacks one CSI-2 RAW10 long-packet payload (2 bytes/cycle) into
//            10-bit pixel quads, and checks the received line length.
// Revision : 1.0 - initial release
// ============================================================================
module csi2_raw10_line_unpacker #(
    parameter int BYTES_PER_LINE   = 3240,
    parameter int WIDTH_BYTE_COUNT = 13,
    parameter int WIDTH_N_PIXELS   = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               data_in,
    input  logic                      data_valid,
    output logic [39:0]               pix_out,
    output logic                      pix_valid,
    output logic [WIDTH_N_PIXELS-1:0] pix_index,
    output logic                      line_done,
    output logic                      length_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [WIDTH_BYTE_COUNT-1:0] c_BYTES     = WIDTH_BYTE_COUNT'(BYTES_PER_LINE);
    localparam logic [WIDTH_BYTE_COUNT-1:0] c_BYTE_STEP = WIDTH_BYTE_COUNT'(2);
    localparam logic [WIDTH_N_PIXELS-1:0]   c_PIX_STEP  = WIDTH_N_PIXELS'(4);

    // p_i = {B_i, B4 low-bit pair i}; quad is {p3,p2,p1,p0} with p0 at [9:0]
    function automatic logic [39:0] f_quad(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [7:0] b4);
        f_quad = {b3, b4[7:6], b2, b4[5:4], b1, b4[3:2], b0, b4[1:0]};
    endfunction

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [WIDTH_BYTE_COUNT-1:0] r_byte_count;
    logic [2:0]                  r_phase;
    logic [WIDTH_N_PIXELS-1:0]   r_pix_count;
    logic [7:0]                  r_b0, r_b1, r_b2, r_b3;
    logic                        r_overrun;
    logic [39:0]                 r_pix_out;
    logic                        r_pix_valid;
    logic [WIDTH_N_PIXELS-1:0]   r_pix_index;
    logic                        r_line_done;
    logic                        r_length_error;

    logic        w_at_limit;
    logic        w_consume;
    logic        w_eol;
    logic        w_err;
    logic        w_overrun_set;
    logic        w_emit;
    logic [39:0] w_quad;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;

    assign w_lo       = data_in[7:0];
    assign w_hi       = data_in[15:8];
    assign w_at_limit = (r_byte_count == c_BYTES);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: a low data_valid always ends the line; pairs past the limit divert to DROP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (data_valid) w_state_nxt = S_RECV;
            S_RECV:  if (!data_valid)    w_state_nxt = S_IDLE;
                     else if (w_at_limit) w_state_nxt = S_DROP;
            S_DROP:  if (!data_valid)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: which pairs are consumed, when the line ends, and whether it was bad
    always_comb begin
        w_consume     = data_valid && ((r_state == S_IDLE) || ((r_state == S_RECV) && !w_at_limit));
        w_overrun_set = data_valid && (r_state == S_RECV) && w_at_limit;
        w_eol         = !data_valid && ((r_state == S_RECV) || (r_state == S_DROP));
        w_err         = w_eol && ((r_state == S_DROP) || r_overrun || !w_at_limit);
        w_emit        = w_consume && ((r_phase == 3'd2) || (r_phase == 3'd4));
        // Phase 2 closes an even group with B4 in the low byte; phase 4 with B3,B4 in this pair
        w_quad        = (r_phase == 3'd2) ? f_quad(r_b0, r_b1, r_b2, r_b3, w_lo)
                                          : f_quad(r_b0, r_b1, r_b2, w_lo, w_hi);
    end

    // Datapath: byte/pixel counters, holding bytes and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_count   <= '0;
            r_phase        <= '0;
            r_pix_count    <= '0;
            r_b0           <= '0;
            r_b1           <= '0;
            r_b2           <= '0;
            r_b3           <= '0;
            r_overrun      <= 1'b0;
            r_pix_out      <= '0;
            r_pix_valid    <= 1'b0;
            r_pix_index    <= '0;
            r_line_done    <= 1'b0;
            r_length_error <= 1'b0;
        end else begin
            r_line_done    <= w_eol;
            r_length_error <= w_err;
            r_pix_valid    <= w_emit;
            if (w_emit) begin
                r_pix_out   <= w_quad;
                r_pix_index <= r_pix_count;
                r_pix_count <= r_pix_count + c_PIX_STEP;
            end
            if (w_overrun_set) r_overrun <= 1'b1;
            if (w_eol) begin
                r_byte_count <= '0;
                r_phase      <= '0;
                r_pix_count  <= '0;
                r_b0         <= '0;
                r_b1         <= '0;
                r_b2         <= '0;
                r_b3         <= '0;
                r_overrun    <= 1'b0;
            end else if (w_consume) begin
                r_byte_count <= r_byte_count + c_BYTE_STEP;
                r_phase      <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
                case (r_phase)
                    3'd0: begin r_b0 <= w_lo; r_b1 <= w_hi; end
                    3'd1: begin r_b2 <= w_lo; r_b3 <= w_hi; end
                    3'd2: r_b0 <= w_hi;  // first byte of the next (odd) group
                    3'd3: begin r_b1 <= w_lo; r_b2 <= w_hi; end
                    default: ;
                endcase
            end
        end
    end

    assign pix_out      = r_pix_out;
    assign pix_valid    = r_pix_valid;
    assign pix_index    = r_pix_index;
    assign line_done    = r_line_done;
    assign length_error = r_length_error;

endmodule
`default_nettype wire

// File: tb/tb_csi2_raw10_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_raw10_line_unpacker
// Brief    : Directed self-checking bench for csi2_raw10_line_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_raw10_line_unpacker;

    localparam int c_BYTES  = 3240;
    localparam int c_PAIRS  = c_BYTES / 2;
    localparam int c_QUADS  = c_BYTES / 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic [39:0] pix_out;
    logic        pix_valid;
    logic [12:0] pix_index;
    logic        line_done;
    logic        length_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csi2_raw10_line_unpacker #(
        .BYTES_PER_LINE   (c_BYTES),
        .WIDTH_BYTE_COUNT (13),
        .WIDTH_N_PIXELS   (13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .pix_index    (pix_index),
        .line_done    (line_done),
        .length_error (length_error)
    );

    // Stream byte n of a line is (n + base) mod 256
    function automatic logic [7:0] f_byte(input int n, input int base);
        f_byte = 8'((n + base) & 255);
    endfunction

    // Expected quad q of a line built from f_byte, straight from the RAW10 byte layout
    function automatic logic [39:0] f_exp_quad(input int q, input int base);
        logic [7:0]  b4;
        logic [39:0] r;
        b4 = f_byte(5 * q + 4, base);
        r  = '0;
        for (int i = 0; i < 4; i++)
            r[10 * i +: 10] = {f_byte(5 * q + i, base), b4[2 * i +: 2]};
        f_exp_quad = r;
    endfunction

    // Drives n_pairs of incrementing bytes and checks every cycle's pixel outputs
    task automatic drive_line(input int n_pairs, input int base, output int n_quads, output int last_idx);
        logic        exp_v;
        int          q;
        n_quads  = 0;
        last_idx = -1;
        for (int k = 0; k < n_pairs; k++) begin
            data_in    = {f_byte(2 * k + 1, base), f_byte(2 * k, base)};
            data_valid = 1'b1;
            @(posedge clk); #1;
            exp_v = (k < c_PAIRS) && ((k % 5 == 2) || (k % 5 == 4));
            n_tests++;
            if (pix_valid !== exp_v) begin
                n_fail++;
                $display("FAIL pix_valid pair %0d: got %b expected %b", k, pix_valid, exp_v);
            end
            n_tests++;
            if (line_done !== 1'b0) begin
                n_fail++;
                $display("FAIL line_done_midline pair %0d: got %b expected 0", k, line_done);
            end
            if (exp_v) begin
                q = 2 * (k / 5) + ((k % 5 == 4) ? 1 : 0);
                n_tests++;
                if (pix_out !== f_exp_quad(q, base)) begin
                    n_fail++;
                    $display("FAIL pix_out quad %0d: got %h expected %h", q, pix_out, f_exp_quad(q, base));
                end
                n_tests++;
                if (pix_index !== 13'(4 * q)) begin
                    n_fail++;
                    $display("FAIL pix_index quad %0d: got %0d expected %0d", q, pix_index, 4 * q);
                end
                n_quads++;
                last_idx = int'(pix_index);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({pix_out, pix_valid, pix_index, line_done, length_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b/%0d/%b/%b expected all zero",
                     pix_out, pix_valid, pix_index, line_done, length_error);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ld=%b pv=%b expected 0/0", line_done, pix_valid);
        end
    endtask

    task automatic test_single_group();
        logic [15:0] pairs [3];
        logic [39:0] exp_q;
        pairs[0] = 16'h3412;
        pairs[1] = 16'h7856;
        pairs[2] = 16'hAAE4;
        exp_q    = {10'h1E3, 10'h15A, 10'h0D1, 10'h048};
        for (int k = 0; k < 3; k++) begin
            data_in    = pairs[k];
            data_valid = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (pix_valid !== (k == 2)) begin
                n_fail++;
                $display("FAIL single_pix_valid pair %0d: got %b expected %b", k, pix_valid, (k == 2));
            end
        end
        n_tests++;
        if (pix_out !== exp_q || pix_index !== 13'd0) begin
            n_fail++;
            $display("FAIL single_quad: got %h idx %0d expected %h idx 0", pix_out, pix_index, exp_q);
        end
        data_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b1 || length_error !== 1'b1 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_eol: got ld=%b le=%b pv=%b expected 1/1/0", line_done, length_error, pix_valid);
        end
        n_tests++;
        if (pix_out !== exp_q) begin
            n_fail++;
            $display("FAIL single_hold: got %h expected %h", pix_out, exp_q);
        end
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b0 || length_error !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: got ld=%b le=%b expected 0/0", line_done, length_error);
        end
    endtask

    task automatic check_eol(input string name, input logic exp_err, input int n_quads, input int exp_quads,
                             input int last_idx, input int exp_last);
        n_tests++;
        if (n_quads != exp_quads || last_idx != exp_last) begin
            n_fail++;
            $display("FAIL %s_count: got %0d quads last %0d expected %0d last %0d",
                     name, n_quads, last_idx, exp_quads, exp_last);
        end
        data_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b1 || length_error !== exp_err || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_eol: got ld=%b le=%b pv=%b expected 1/%b/0",
                     name, line_done, length_error, pix_valid, exp_err);
        end
    endtask

    task automatic test_full_line();
        int nq, li;
        drive_line(c_PAIRS, 0, nq, li);
        check_eol("full", 1'b0, nq, c_QUADS, li, 4 * (c_QUADS - 1));
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pulse_width: got ld=%b expected 0", line_done);
        end
    endtask

    task automatic test_short_line();
        int nq, li;
        drive_line(7, 16'h21, nq, li);
        check_eol("short", 1'b1, nq, 2, li, 4);
        @(posedge clk); #1;
    endtask

    task automatic test_long_line();
        int nq, li;
        drive_line(c_PAIRS + 2, 16'h90, nq, li);
        check_eol("long", 1'b1, nq, c_QUADS, li, 4 * (c_QUADS - 1));
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int nq, li;
        drive_line(c_PAIRS, 16'h10, nq, li);
        check_eol("b2b_first", 1'b0, nq, c_QUADS, li, 4 * (c_QUADS - 1));
        // Next line begins on the cycle line_done is high
        drive_line(c_PAIRS, 16'h55, nq, li);
        check_eol("b2b_second", 1'b0, nq, c_QUADS, li, 4 * (c_QUADS - 1));
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midline();
        int nq, li;
        drive_line(100, 16'h7, nq, li);
        rst        = 1'b1;
        data_valid = 1'b0;
        #1;
        n_tests++;
        if ({pix_out, pix_valid, pix_index, line_done, length_error} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h/%b/%0d/%b/%b expected all zero",
                     pix_out, pix_valid, pix_index, line_done, length_error);
        end
        repeat (2) begin
            @(posedge clk); #1;
            n_tests++;
            if (line_done !== 1'b0 || pix_out !== '0) begin
                n_fail++;
                $display("FAIL midreset_hold: got ld=%b pix %h expected 0/0", line_done, pix_out);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (line_done !== 1'b0 || length_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_eol: got ld=%b le=%b expected 0/0", line_done, length_error);
        end
        drive_line(c_PAIRS, 16'h33, nq, li);
        check_eol("after_reset", 1'b0, nq, c_QUADS, li, 4 * (c_QUADS - 1));
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_full_line();
        test_short_line();
        test_long_line();
        test_back_to_back();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
